// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one iterative CORDIC core among N_REQ requesters (round-robin, optional ownership lock, done watchdog).
// Latency: accept at T, cor_enable at T+1, rsp_valid one cycle after cor_done (or TIMEOUT cycles into WAIT on abort).
// Backpressure: requesters hold req_valid until their req_ready strobe; one operation in flight, other requests wait.
module cordic_arbiter #(
  parameter int N_REQ   = 3,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*DW-1:0]        req_x,
  input  logic [N_REQ*DW-1:0]        req_y,
  input  logic [N_REQ*DW-1:0]        req_z,
  input  logic [N_REQ-1:0]           req_mode,
  input  logic [N_REQ-1:0]           req_lock,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [DW-1:0]              rsp_x,
  output logic [DW-1:0]              rsp_y,
  output logic [DW-1:0]              rsp_z,
  output logic                       rsp_err,
  output logic                       cor_enable,
  output logic                       cor_select,
  output logic [DW-1:0]              cor_x_in,
  output logic [DW-1:0]              cor_y_in,
  output logic [DW-1:0]              cor_z_in,
  input  logic                       cor_done,
  input  logic [DW-1:0]              cor_x_out,
  input  logic [DW-1:0]              cor_y_out,
  input  logic [DW-1:0]              cor_z_out,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            lock_q, lock_d;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   owner_q;

  // Latched operation of the current owner
  logic [DW-1:0]   op_x_q, op_y_q, op_z_q;
  logic            op_mode_q, op_lock_q;

  // Result registers, held until the next response
  logic [DW-1:0]   rsp_x_q, rsp_y_q, rsp_z_q;
  logic            rsp_err_q;

  // Arbitration result and FSM strobes
  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   rr_next;
  logic            accept;
  logic            cap_done;
  logic            cap_tmo;

  // Grant: locked owner only, else first valid requester from the rr pointer upward with wrap
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (lock_q) begin
      grant_vld = req_valid[owner_q];
      grant_idx = owner_q;
    end else begin
      // Walk offsets from far to near so the nearest valid requester wins
      for (int i = N_REQ - 1; i >= 0; i--) begin
        cand = IW'((int'(rr_q) + i) % N_REQ);
        if (req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // Pointer moves just past the winner so every requester gets a turn
  always_comb begin
    rr_next = IW'((int'(grant_idx) + 1) % N_REQ);
  end

  // FSM next state, timer, lock flag and handshake strobes
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    lock_d     = lock_q;
    accept     = 1'b0;
    cap_done   = 1'b0;
    cap_tmo    = 1'b0;
    cor_enable = 1'b0;
    req_ready  = '0;
    rsp_valid  = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_d              = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cor_enable = 1'b1;
        timer_d    = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // done has priority over a timeout in the same cycle
        if (cor_done) begin
          cap_done = 1'b1;
          state_d  = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          cap_tmo = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        // An aborted operation always releases ownership
        lock_d  = rsp_err_q ? 1'b0 : op_lock_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, watchdog timer and lock flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lock_q  <= lock_d;
    end
  end

  // Latch the winner's operands, owner and rr pointer on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_x_q    <= '0;
      op_y_q    <= '0;
      op_z_q    <= '0;
      op_mode_q <= 1'b0;
      op_lock_q <= 1'b0;
      owner_q   <= '0;
      rr_q      <= '0;
    end else if (accept) begin
      op_x_q    <= req_x[grant_idx*DW +: DW];
      op_y_q    <= req_y[grant_idx*DW +: DW];
      op_z_q    <= req_z[grant_idx*DW +: DW];
      op_mode_q <= req_mode[grant_idx];
      op_lock_q <= req_lock[grant_idx];
      owner_q   <= grant_idx;
      rr_q      <= rr_next;
    end
  end

  // Capture CORDIC results on done, or clear them and flag an error on timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_x_q   <= '0;
      rsp_y_q   <= '0;
      rsp_z_q   <= '0;
      rsp_err_q <= 1'b0;
    end else if (cap_done) begin
      rsp_x_q   <= cor_x_out;
      rsp_y_q   <= cor_y_out;
      rsp_z_q   <= cor_z_out;
      rsp_err_q <= 1'b0;
    end else if (cap_tmo) begin
      rsp_x_q   <= '0;
      rsp_y_q   <= '0;
      rsp_z_q   <= '0;
      rsp_err_q <= 1'b1;
    end
  end

  // CORDIC operands come straight from the latched registers, so they stay stable through WAIT
  assign cor_select = op_mode_q;
  assign cor_x_in   = op_x_q;
  assign cor_y_in   = op_y_q;
  assign cor_z_in   = op_z_q;

  assign rsp_x   = rsp_x_q;
  assign rsp_y   = rsp_y_q;
  assign rsp_z   = rsp_z_q;
  assign rsp_err = rsp_err_q;

  assign busy  = (state_q != S_IDLE) || lock_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed scoreboard bench for cordic_arbiter with a behavioural CORDIC core.
// Latency: checks accept->enable, done->response and timeout response timing.
// Backpressure: requesters hold req_valid until their req_ready strobe.
module tb_cordic_arbiter;
  localparam int N   = 3;
  localparam int DW  = 32;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready, req_mode, req_lock, rsp_valid;
  logic [N*DW-1:0] req_x, req_y, req_z;
  logic [DW-1:0]   rsp_x, rsp_y, rsp_z, cor_x_in, cor_y_in, cor_z_in;
  logic [DW-1:0]   cor_x_out, cor_y_out, cor_z_out;
  logic            rsp_err, cor_enable, cor_select, cor_done, busy;
  logic [1:0]      owner;

  always #5 clk = ~clk;

  cordic_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .req_mode(req_mode), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .cor_enable(cor_enable), .cor_select(cor_select),
    .cor_x_in(cor_x_in), .cor_y_in(cor_y_in), .cor_z_in(cor_z_in),
    .cor_done(cor_done), .cor_x_out(cor_x_out), .cor_y_out(cor_y_out), .cor_z_out(cor_z_out),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    logic [31:0] x, y, z;
    logic        mode, lock;
  } op_t;

  typedef struct {
    int          idx;
    logic [31:0] x, y, z;
    logic        err, lock;
  } exp_t;

  op_t  rq0[$], rq1[$], rq2[$];
  exp_t exp_q[$];
  int   acc_cyc_log[$];

  int   errs = 0, checks = 0;
  int   cyc = 0;
  int   rsp_cnt = 0, last_rsp_cyc = 0, last_err_rsp_cyc = 0;
  int   last_acc_cyc = 0;
  op_t  last_acc_op;
  int   cor_lat = 0, mcnt = 0, en_cnt = 0, last_en_cyc = 0, last_done_cyc = 0;
  logic [31:0] last_en_z = '0;
  bit   spur_idle = 1'b0, spur_issue = 1'b0;
  op_t  mop;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int qsz(input int k);
    case (k)
      0:       return rq0.size();
      1:       return rq1.size();
      default: return rq2.size();
    endcase
  endfunction

  function automatic op_t qfront(input int k);
    case (k)
      0:       return rq0[0];
      1:       return rq1[0];
      default: return rq2[0];
    endcase
  endfunction

  task automatic qpop(input int k);
    case (k)
      0:       void'(rq0.pop_front());
      1:       void'(rq1.pop_front());
      default: void'(rq2.pop_front());
    endcase
  endtask

  task automatic issue(input int k, input logic [31:0] x, y, z, input logic mode, lock);
    op_t o;
    o.x = x; o.y = y; o.z = z; o.mode = mode; o.lock = lock;
    case (k)
      0:       rq0.push_back(o);
      1:       rq1.push_back(o);
      default: rq2.push_back(o);
    endcase
  endtask

  task automatic expect_rsp(input int k, input logic [31:0] x, y, z, input logic err, lock);
    exp_t e;
    e.idx = k; e.x = x; e.y = y; e.z = z; e.err = err; e.lock = lock;
    exp_q.push_back(e);
  endtask

  // Requester driver: present queue heads at negedge, record accepts just before the next posedge
  initial begin
    logic [N-1:0] acc;
    op_t o;
    acc = '0;
    req_valid = '0; req_mode = '0; req_lock = '0;
    req_x = '0; req_y = '0; req_z = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) if (acc[k]) qpop(k);
      for (int k = 0; k < N; k++) begin
        if (qsz(k) > 0) begin
          o = qfront(k);
          req_valid[k] = 1'b1;
          req_x[k*DW +: DW] = o.x;
          req_y[k*DW +: DW] = o.y;
          req_z[k*DW +: DW] = o.z;
          req_mode[k] = o.mode;
          req_lock[k] = o.lock;
        end else begin
          req_valid[k] = 1'b0;
        end
      end
      #1;
      acc = rst_n ? (req_valid & req_ready) : '0;
      if (req_ready != '0) chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          last_acc_cyc = cyc;
          last_acc_op  = qfront(k);
          acc_cyc_log.push_back(cyc);
        end
      end
    end
  end

  // Behavioural CORDIC: done cor_lat cycles after the enable cycle (0 = never)
  initial begin
    cor_done = 1'b0; cor_x_out = '0; cor_y_out = '0; cor_z_out = '0;
    forever begin
      @(negedge clk);
      cor_done = 1'b0;
      cor_x_out = 32'hBAD0_BAD0; cor_y_out = 32'hBAD1_BAD1; cor_z_out = 32'hBAD2_BAD2;
      if (!rst_n) begin
        mcnt = 0;
      end else begin
        if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) begin
            cor_done = 1'b1;
            last_done_cyc = cyc;
            if (mop.mode) begin
              cor_x_out = mop.x + {mop.y[31], mop.y[31:1]};
              cor_y_out = '0;
              cor_z_out = mop.z + 32'h100;
            end else begin
              cor_x_out = mop.x - mop.y;
              cor_y_out = mop.x + mop.y;
              cor_z_out = '0;
            end
            chk("cor_x_in_stable", cor_x_in, mop.x);
          end
        end
        if (cor_enable) begin
          en_cnt++;
          last_en_cyc = cyc;
          last_en_z = cor_z_in;
          chk("enable_latency", cyc, last_acc_cyc + 1);
          chk("cor_x_in", cor_x_in, last_acc_op.x);
          chk("cor_y_in", cor_y_in, last_acc_op.y);
          chk("cor_z_in", cor_z_in, last_acc_op.z);
          chk("cor_select", 32'(cor_select), 32'(last_acc_op.mode));
          mop.x = cor_x_in; mop.y = cor_y_in; mop.z = cor_z_in; mop.mode = cor_select; mop.lock = 1'b0;
          mcnt = cor_lat;
          if (spur_issue) begin
            cor_done = 1'b1;
            spur_issue = 1'b0;
          end
        end
        if (spur_idle) begin
          cor_done = 1'b1;
          spur_idle = 1'b0;
        end
      end
    end
  end

  // Monitor: pop the scoreboard on every response and compare
  initial begin
    bit   bchk;
    logic bexp;
    exp_t e;
    bchk = 1'b0; bexp = 1'b0;
    forever begin
      @(negedge clk);
      if (bchk) begin
        chk("busy_after_rsp", 32'(busy), 32'(bexp));
        bchk = 1'b0;
      end
      if (rsp_valid != '0) begin
        rsp_cnt++;
        last_rsp_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with no response pending (cycle %0d)", rsp_valid, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid_owner", 32'(rsp_valid), 32'(1 << e.idx));
          chk("owner", 32'(owner), 32'(e.idx));
          chk("rsp_x", rsp_x, e.x);
          chk("rsp_y", rsp_y, e.y);
          chk("rsp_z", rsp_z, e.z);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          if (e.err) begin
            last_err_rsp_cyc = cyc;
            chk("timeout_latency", cyc, last_en_cyc + 1 + TMO);
          end else begin
            chk("done_latency", cyc, last_done_cyc + 1);
          end
          bchk = 1'b1;
          bexp = e.lock & ~e.err;
        end
      end
    end
  end

  task automatic chk_outputs_zero(input string nm);
    chk(nm, 32'({req_ready, rsp_valid, rsp_err, cor_enable, cor_select, busy, owner}), 32'd0);
    chk({nm, "_data"}, rsp_x | rsp_y | rsp_z | cor_x_in | cor_y_in | cor_z_in, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || qsz(0) + qsz(1) + qsz(2) != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(exp_q.size() + qsz(0) + qsz(1) + qsz(2)), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_enable(input string nm, input int e0);
    int n;
    n = 0;
    while (en_cnt == e0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(en_cnt), 32'(e0 + 1));
  endtask

  initial begin
    int a0, n0, e0;
    do_reset();

    // 1: single vectoring op, 16-cycle CORDIC
    cor_lat = 16;
    issue(0, 32'h0003_0000, 32'h0004_0000, 32'h0, 1'b1, 1'b0);
    expect_rsp(0, 32'h0005_0000, 32'h0, 32'h0000_0100, 1'b0, 1'b0);
    wait_drain("drain_t1", 200);

    // 3: rr pointer now 1; req1 locked sequence then 2, 0
    cor_lat = 3;
    issue(1, 32'h10, 32'h4, 32'h7, 1'b0, 1'b1);
    issue(1, 32'h100, 32'h20, 32'h0, 1'b0, 1'b1);
    issue(1, 32'h5, 32'h9, 32'h0, 1'b0, 1'b0);
    issue(2, 32'h2000, 32'h1000, 32'h5, 1'b1, 1'b0);
    issue(0, 32'h7, 32'hFFFF_FFFC, 32'hFFFF_FF00, 1'b1, 1'b0);
    expect_rsp(1, 32'h0000_000C, 32'h0000_0014, 32'h0, 1'b0, 1'b1);
    expect_rsp(1, 32'h0000_00E0, 32'h0000_0120, 32'h0, 1'b0, 1'b1);
    expect_rsp(1, 32'hFFFF_FFFC, 32'h0000_000E, 32'h0, 1'b0, 1'b0);
    expect_rsp(2, 32'h0000_2800, 32'h0, 32'h0000_0105, 1'b0, 1'b0);
    expect_rsp(0, 32'h0000_0005, 32'h0, 32'h0000_0000, 1'b0, 1'b0);
    wait_drain("drain_t3", 300);

    // 2: pointer back to 0; all three contend with two ops each
    do_reset();
    cor_lat = 2;
    a0 = acc_cyc_log.size();
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < N; k++) begin
        issue(k, 32'(32'h100 * (k + 1) + j), 32'h1, 32'h0, 1'b0, 1'b0);
        expect_rsp(k, 32'(32'h100 * (k + 1) + j - 1), 32'(32'h100 * (k + 1) + j + 1), 32'h0, 1'b0, 1'b0);
      end
    end
    wait_drain("drain_t2", 300);
    for (int i = 1; i < 6; i++)
      chk("b2b_interval", 32'(acc_cyc_log[a0 + i] - acc_cyc_log[a0 + i - 1]), 32'd5);

    // 4: CORDIC never finishes; locked op aborts, then pending req2 goes next cycle
    cor_lat = 0;
    e0 = en_cnt;
    issue(1, 32'h9, 32'h9, 32'h9, 1'b0, 1'b1);
    expect_rsp(1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    wait_enable("t4_enable", e0);
    cor_lat = 3;
    issue(2, 32'h40, 32'h40, 32'h0, 1'b1, 1'b0);
    expect_rsp(2, 32'h60, 32'h0, 32'h100, 1'b0, 1'b0);
    wait_drain("drain_t4", 300);
    chk("tmo_next_grant", 32'(acc_cyc_log[acc_cyc_log.size() - 1]), 32'(last_err_rsp_cyc + 1));

    // 5: spurious done in IDLE and ISSUE, then done coincident with timeout
    n0 = rsp_cnt;
    spur_idle = 1'b1;
    repeat (4) @(negedge clk);
    chk("spur_idle_no_rsp", 32'(rsp_cnt), 32'(n0));
    cor_lat = 4;
    spur_issue = 1'b1;
    issue(0, 32'h1000, 32'h0800, 32'h1, 1'b1, 1'b0);
    expect_rsp(0, 32'h1400, 32'h0, 32'h101, 1'b0, 1'b0);
    wait_drain("drain_t5a", 100);
    cor_lat = TMO;
    issue(1, 32'h55, 32'h11, 32'h0, 1'b0, 1'b0);
    expect_rsp(1, 32'h44, 32'h66, 32'h0, 1'b0, 1'b0);
    wait_drain("drain_t5b", 200);

    // 6: reset during WAIT abandons the op; then a clean req2 rotation
    cor_lat = 0;
    e0 = en_cnt;
    issue(0, 32'h123, 32'h456, 32'h789, 1'b0, 1'b1);
    wait_enable("t6_enable", e0);
    repeat (3) @(negedge clk);
    n0 = rsp_cnt;
    do_reset();
    repeat (3) @(negedge clk);
    chk("reset_no_rsp", 32'(rsp_cnt), 32'(n0));
    cor_lat = 5;
    issue(2, 32'h30, 32'h10, 32'h0010_0000, 1'b0, 1'b0);
    expect_rsp(2, 32'h20, 32'h40, 32'h0, 1'b0, 1'b0);
    wait_drain("drain_t6", 100);
    chk("t6_cor_z_in", last_en_z, 32'h0010_0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one iterative CORDIC core among N_REQ requesters, for example the QR decomposition controller, the back-substitution unit and the Q-matrix builder of the matrix-inverse datapath.
- Each requester issues vectoring or rotation operations through a valid/ready handshake and receives the result as a one-cycle response pulse.
- Round-robin arbitration between requesters; an optional lock lets one requester run a dependent sequence uninterrupted (vectoring followed by rotations that reuse theta).
- Includes a done-timeout watchdog.

Parameters:
N_REQ, 3, number of requesters (2..8)
DW, 32, signed operand/result width
TIMEOUT, 64, max cycles in WAIT before abort with error (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  N_REQ  per-requester operation request
req_ready  out  N_REQ  accept strobe; at most one bit high per cycle
req_x  in  N_REQ*DW  x operand; requester k uses slice [k*DW +: DW]
req_y  in  N_REQ*DW  y operand, same packing
req_z  in  N_REQ*DW  z operand (angle), same packing
req_mode  in  N_REQ  1 = vectoring, 0 = rotation
req_lock  in  N_REQ  1 = keep ownership after this operation
rsp_valid  out  N_REQ  one-cycle result pulse to owner
rsp_x  out  DW  result x (shared bus)
rsp_y  out  DW  result y
rsp_z  out  DW  result z
rsp_err  out  1  qualifies rsp_valid: timeout abort
cor_enable  out  1  one-cycle start to CORDIC
cor_select  out  1  CORDIC mode (1 = vectoring)
cor_x_in  out  DW  CORDIC operand x
cor_y_in  out  DW  CORDIC operand y
cor_z_in  out  DW  CORDIC operand z
cor_done  in  1  CORDIC result ready
cor_x_out  in  DW  CORDIC result x
cor_y_out  in  DW  CORDIC result y
cor_z_out  in  DW  CORDIC result z
busy  out  1  state != IDLE or lock held
owner  out  $clog2(N_REQ)  index of current or last grantee

Behaviour:
- Reset values: state IDLE; all outputs 0; rr pointer 0; lock flag clear; timer 0; operand and result registers 0.
- Reset mid-operation abandons the transaction. No rsp_valid is issued.

State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.

IDLE:
- Grant is computed combinationally from req_valid.
- Lock clear: winner is the first requester with req_valid=1, searching from the rr pointer upward with wrap.
- Lock set: only owner is eligible; other requests wait.
- req_ready[winner]=1 in this cycle. req_ready may depend on req_valid.
- On accept: latch x/y/z/mode/lock of the winner, set owner=winner, set rr pointer=(winner+1) mod N_REQ, go to ISSUE.
- No eligible request: stay in IDLE.

ISSUE (1 cycle):
- cor_enable=1.
- cor_x_in/cor_y_in/cor_z_in/cor_select driven from the latched registers.
- Go to WAIT with timer=0.

WAIT:
- cor_* inputs stay stable; cor_enable=0.
- cor_done=1: capture cor_x_out/cor_y_out/cor_z_out into rsp registers, rsp_err=0, go to RESP.
- Otherwise timer increments. When timer reaches TIMEOUT-1 with no done: rsp regs=0, rsp_err=1, go to RESP.
- Done and timeout in the same cycle: done wins.

RESP (1 cycle):
- rsp_valid[owner]=1. rsp_x/y/z/err stay valid until the next RESP.
- Lock flag update:
  - rsp_err=1: lock := 0.
  - Otherwise: lock := latched req_lock.
- Go to IDLE.

Other rules:
- cor_done is sampled only in WAIT; done in any other state is ignored.
- Latency: accept at cycle T, cor_enable at T+1. If cor_done is first seen at cycle D (D >= T+2), rsp_valid is at D+1. Earliest next accept is D+2. Back-to-back throughput is CORDIC latency + 3 cycles.
- Arithmetic: pure pass-through; no truncation or sign change of operands or results.
- Locked owner deasserts req_valid: arbiter waits indefinitely with busy=1. Only an operation with lock=0, a timeout, or reset releases the lock.

Test Plan:
1. Req0 vectoring, x=0x00030000, y=0x00040000, z=0; CORDIC model returns done after 16 cycles with x_out=0x00050000 -> req_ready[0] at T, cor_enable and cor_select=1 at T+1, rsp_valid[0] one cycle after done, rsp_x=0x00050000, rsp_err=0.
2. All three req_valid held high, lock=0, each requester issuing 2 ops -> grant order 0,1,2,0,1,2. Exactly one req_ready bit high per accept.
3. Req1 issues 3 ops with lock=1,1,0 while req0 and req2 keep valid high, pointer at 1 -> service order 1,1,1,2,0. busy stays 1 between req1 ops.
4. CORDIC model never asserts done -> rsp_valid[owner] with rsp_err=1 exactly TIMEOUT cycles after entering WAIT. Lock clears; the next pending request is granted on the following cycle.
5. Spurious cor_done pulses in IDLE and ISSUE -> no rsp_valid. Done and timeout coincident -> rsp_err=0 with the captured data.
6. rst_n low for 2 cycles during WAIT -> all outputs 0 immediately and no rsp_valid. After release, a req2 rotation with z=0x00100000 completes normally with cor_z_in=0x00100000.
